// File: rtl/axis_uart_tx_arb.sv
// axis_uart_tx_arb
//   Packet-granular round-robin arbiter. It shares one AXI-Stream sink (the FIFO/UART TX path)
//   among NUM_REQ byte-stream sources. A grant is held for a whole packet, which ends at the
//   beat with last set, so packets from different sources never interleave.
//
//   Optional feature macro: ARB_TIMEOUT_EN. When it is defined, a grant whose owner stays
//   idle (valid low) for TIMEOUT consecutive cycles is revoked and err_timeout pulses.
//
// Ports
//   i_clk, i_rst     : clock and synchronous active-high reset
//   i_s_axis_data    : source data, source i at [i*WIDTH +: WIDTH]
//   i_s_axis_valid   : per-source valid
//   i_s_axis_last    : per-source end of packet
//   o_s_axis_ready   : per-source ready, at most one bit high
//   o_m_axis_data    : data to the TX sink
//   o_m_axis_valid   : valid to the TX sink
//   o_m_axis_last    : last to the TX sink
//   i_m_axis_ready   : ready from the TX sink
//   o_grant          : registered one-hot owner, zero when idle
//   o_busy           : high while a grant is held
//   o_err_timeout    : one-cycle pulse when a grant is revoked (tied low without the macro)
module axis_uart_tx_arb #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [NUM_REQ*WIDTH-1:0] i_s_axis_data,
   input  logic [NUM_REQ-1:0]       i_s_axis_valid,
   input  logic [NUM_REQ-1:0]       i_s_axis_last,
   output logic [NUM_REQ-1:0]       o_s_axis_ready,
   output logic [WIDTH-1:0]         o_m_axis_data,
   output logic                     o_m_axis_valid,
   output logic                     o_m_axis_last,
   input  logic                     i_m_axis_ready,
   output logic [NUM_REQ-1:0]       o_grant,
   output logic                     o_busy,
   output logic                     o_err_timeout
);

   localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {StIdle, StGrant} state_e;

   state_e             r_state, w_state_nxt;
   logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
   logic [IdxW-1:0]    r_last_grant, w_last_grant_nxt;
   logic [IdxW-1:0]    w_owner, w_pick;
   logic               w_pick_vld;
   logic               w_own_valid, w_own_last;
   logic [WIDTH-1:0]   w_own_data;
   logic               w_pkt_end;
   logic               w_timeout;

   // Owner index and its stream signals, decoded from the one-hot grant.
   always_comb begin
      w_owner     = '0;
      w_own_valid = 1'b0;
      w_own_last  = 1'b0;
      w_own_data  = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (r_grant[i]) begin
            w_owner     = IdxW'(i);
            w_own_valid = i_s_axis_valid[i];
            w_own_last  = i_s_axis_last[i];
            w_own_data  = i_s_axis_data[i*WIDTH +: WIDTH];
         end
      end
   end

   // Round-robin search from last_grant+1. Walking from the farthest candidate back toward
   // last_grant+1 lets the nearest valid source overwrite the others.
   always_comb begin
      int unsigned v_idx;
      v_idx      = 0;
      w_pick     = '0;
      w_pick_vld = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         v_idx = (int'(r_last_grant) + k) % NUM_REQ;
         if (i_s_axis_valid[v_idx]) begin
            w_pick     = IdxW'(v_idx);
            w_pick_vld = 1'b1;
         end
      end
   end

   assign w_pkt_end = (r_state == StGrant) & w_own_valid & i_m_axis_ready & w_own_last;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= StIdle;
         r_grant      <= '0;
         r_last_grant <= IdxW'(NUM_REQ - 1);
      end else begin
         r_state      <= w_state_nxt;
         r_grant      <= w_grant_nxt;
         r_last_grant <= w_last_grant_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt      = r_state;
      w_grant_nxt      = r_grant;
      w_last_grant_nxt = r_last_grant;
      unique case (r_state)
         StIdle: begin
            if (w_pick_vld) begin
               w_state_nxt = StGrant;
               w_grant_nxt = NUM_REQ'(1) << w_pick;
            end
         end
         StGrant: begin
            if (w_pkt_end || w_timeout) begin
               w_state_nxt      = StIdle;
               w_grant_nxt      = '0;
               w_last_grant_nxt = w_owner;
            end
         end
         default: w_state_nxt = StIdle;
      endcase
   end

   // Outputs: the data path is combinational from the registered grant.
   always_comb begin
      o_s_axis_ready = '0;
      o_m_axis_data  = '0;
      o_m_axis_valid = 1'b0;
      o_m_axis_last  = 1'b0;
      if (r_state == StGrant) begin
         o_m_axis_data  = w_own_data;
         o_m_axis_valid = w_own_valid;
         o_m_axis_last  = w_own_last;
         o_s_axis_ready = r_grant & {NUM_REQ{i_m_axis_ready}};
      end
   end

   assign o_grant = r_grant;
   assign o_busy  = (r_state == StGrant);

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT + 1);

   logic [CntW-1:0] r_stall_cnt;
   logic            r_err_timeout;

   // Revoke on the edge at which the idle-cycle count reaches TIMEOUT. Backpressure does not
   // count because the owner's valid is still high then.
   assign w_timeout = (r_state == StGrant) & ~w_own_valid &
                      (r_stall_cnt == CntW'(TIMEOUT - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_stall_cnt   <= '0;
         r_err_timeout <= 1'b0;
      end else begin
         r_err_timeout <= w_timeout;
         if ((r_state != StGrant) || w_own_valid) begin
            r_stall_cnt <= '0;
         end else if (r_stall_cnt != CntW'(TIMEOUT)) begin
            r_stall_cnt <= r_stall_cnt + CntW'(1);
         end
      end
   end

   assign o_err_timeout = r_err_timeout;
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT == 0);
   assign w_timeout        = 1'b0;
   assign o_err_timeout    = 1'b0;
`endif

endmodule

// File: tb/tb_axis_uart_tx_arb.sv
// Bench for axis_uart_tx_arb: directed packet scenarios, a cycle-level reference model of the
// arbiter's rules, and literal expectations on the transfer log.
module tb_axis_uart_tx_arb;

   localparam int NUM     = 4;
   localparam int WIDTH   = 8;
   localparam int TIMEOUT = 16;
`ifdef ARB_TIMEOUT_EN
   localparam bit ToEn = 1'b1;
`else
   localparam bit ToEn = 1'b0;
`endif

   logic                 clk;
   logic                 rst;
   logic [NUM*WIDTH-1:0] s_data;
   logic [NUM-1:0]       s_valid, s_last, s_ready;
   logic [WIDTH-1:0]     m_data;
   logic                 m_valid, m_last, m_ready;
   logic [NUM-1:0]       grant;
   logic                 busy, err;

   axis_uart_tx_arb #(
      .NUM_REQ (NUM),
      .WIDTH   (WIDTH),
      .TIMEOUT (TIMEOUT)
   ) u_dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_s_axis_data  (s_data),
      .i_s_axis_valid (s_valid),
      .i_s_axis_last  (s_last),
      .o_s_axis_ready (s_ready),
      .o_m_axis_data  (m_data),
      .o_m_axis_valid (m_valid),
      .o_m_axis_last  (m_last),
      .i_m_axis_ready (m_ready),
      .o_grant        (grant),
      .o_busy         (busy),
      .o_err_timeout  (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Source packet stores: bit 8 is last, bits 7:0 data.
   logic [8:0] src_mem [NUM][32];
   int         src_len [NUM];
   int         src_pos [NUM];
   bit         bp_mode;
   int         bp_cnt;

   task automatic drive();
      for (int i = 0; i < NUM; i++) begin
         if (src_pos[i] < src_len[i]) begin
            s_valid[i]            = 1'b1;
            s_last[i]             = src_mem[i][src_pos[i]][8];
            s_data[i*WIDTH +: WIDTH] = src_mem[i][src_pos[i]][7:0];
         end else begin
            s_valid[i]            = 1'b0;
            s_last[i]             = 1'b0;
            s_data[i*WIDTH +: WIDTH] = '0;
         end
      end
   endtask

   task automatic add_beat(int s, logic [7:0] d, logic l);
      if (src_pos[s] >= src_len[s]) begin
         src_pos[s] = 0;
         src_len[s] = 0;
      end
      src_mem[s][src_len[s]] = {l, d};
      src_len[s]++;
      drive();
   endtask

   task automatic add_pkt(int s, int n, logic [7:0] base);
      for (int k = 0; k < n; k++) add_beat(s, base + 8'(k), (k == n - 1));
   endtask

   task automatic flush();
      for (int i = 0; i < NUM; i++) begin
         src_pos[i] = 0;
         src_len[i] = 0;
      end
      drive();
   endtask

   // One clock: capture handshakes before the edge, advance sources just after it.
   task automatic tick();
      logic [NUM-1:0] fire;
      @(negedge clk);
      fire = s_valid & s_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM; i++) if (fire[i]) src_pos[i]++;
      if (bp_mode) begin
         m_ready = ((bp_cnt % 3) == 0);
         bp_cnt++;
      end
      drive();
   endtask

   // Reference model state: owner index (-1 idle), previous owner, idle counter, error pulse.
   int md_owner, md_lastg, md_cnt;
   bit md_err;
   bit md_live = 1'b0;

   task automatic model_step();
      if (rst) begin
         md_owner = -1;
         md_lastg = NUM - 1;
         md_cnt   = 0;
         md_err   = 1'b0;
         md_live  = 1'b1;
      end else if (md_live) begin
         md_err = 1'b0;
         if (md_owner < 0) begin
            for (int k = 1; k <= NUM; k++) begin
               int c;
               c = (md_lastg + k) % NUM;
               if (s_valid[c]) begin
                  md_owner = c;
                  md_cnt   = 0;
                  break;
               end
            end
         end else if (s_valid[md_owner] && m_ready && s_last[md_owner]) begin
            md_lastg = md_owner;
            md_owner = -1;
         end else if (ToEn) begin
            if (!s_valid[md_owner]) begin
               md_cnt++;
               if (md_cnt >= TIMEOUT) begin
                  md_err   = 1'b1;
                  md_lastg = md_owner;
                  md_owner = -1;
               end
            end else begin
               md_cnt = 0;
            end
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   // Transfer log taken from the DUT's sink side.
   int         log_src [$];
   logic [7:0] log_dat [$];
   logic       log_last[$];
   int         log_cyc [$];
   int         ncyc = 0;

   function automatic int oh2i(logic [NUM-1:0] g);
      for (int i = 0; i < NUM; i++) if (g[i]) return i;
      return -1;
   endfunction

   task automatic log_clear();
      log_src.delete();
      log_dat.delete();
      log_last.delete();
      log_cyc.delete();
   endtask

   // Per-cycle comparison against the model.
   initial begin
      forever begin
         logic [NUM-1:0]   e_grant, e_ready;
         logic             e_valid, e_last;
         logic [WIDTH-1:0] e_data;
         @(negedge clk);
         ncyc++;
         if (md_live) begin
            e_grant = '0;
            e_ready = '0;
            e_valid = 1'b0;
            e_last  = 1'b0;
            e_data  = '0;
            if (md_owner >= 0) begin
               e_grant[md_owner] = 1'b1;
               e_ready[md_owner] = m_ready;
               e_valid           = s_valid[md_owner];
               e_last            = s_last[md_owner];
               e_data            = s_data[md_owner*WIDTH +: WIDTH];
            end
            chk("cyc_grant", grant, e_grant);
            chk("cyc_busy", busy, (md_owner >= 0));
            chk("cyc_err", err, md_err);
            chk("cyc_s_ready", s_ready, e_ready);
            chk("cyc_m_valid", m_valid, e_valid);
            chk("cyc_m_last", m_last, e_last);
            chk("cyc_m_data", m_data, e_data);
            if (m_valid && m_ready) begin
               log_src.push_back(oh2i(grant));
               log_dat.push_back(m_data);
               log_last.push_back(m_last);
               log_cyc.push_back(ncyc);
            end
         end
      end
   end

   task automatic exp_beat(string nm, int idx, int src, logic [7:0] d, logic l);
      if (idx >= log_src.size()) begin
         n_chk++;
         n_err++;
         $display("FAIL %s: beat %0d missing, got %0d beats", nm, idx, log_src.size());
      end else begin
         chk(nm, (log_src[idx] << 16) | (32'(log_dat[idx]) << 8) | 32'(log_last[idx]),
             (src << 16) | (32'(d) << 8) | 32'(l));
      end
   endtask

   task automatic wait_drain(string nm, int limit);
      int  k;
      bit  done;
      k    = 0;
      done = 1'b0;
      while (!done && k < limit) begin
         tick();
         k++;
         done = (busy == 1'b0);
         for (int i = 0; i < NUM; i++) if (src_pos[i] < src_len[i]) done = 1'b0;
      end
      if (!done) begin
         n_chk++;
         n_err++;
         $display("FAIL %s: no drain after %0d cycles, busy %0b", nm, k, busy);
      end
   endtask

   task automatic wait_log(string nm, int n, int limit);
      int k;
      k = 0;
      while (log_src.size() < n && k < limit) begin
         tick();
         k++;
      end
      if (log_src.size() < n) begin
         n_chk++;
         n_err++;
         $display("FAIL %s: %0d beats after %0d cycles, need %0d", nm, log_src.size(), k, n);
      end
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      bp_mode = 1'b0;
      m_ready = 1'b1;
      flush();
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst     = 1'b1;
      m_ready = 1'b1;
      bp_mode = 1'b0;
      bp_cnt  = 0;
      s_valid = '0;
      s_last  = '0;
      s_data  = '0;
      flush();
      tick();
      tick();
      rst = 1'b0;
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_err", err, 0);

      // Single source, three bytes.
      log_clear();
      add_pkt(1, 3, 8'h41);
      chk("t1_grant_pre", grant, 0);
      tick();
      chk("t1_grant", grant, 4'b0010);
      chk("t1_busy", busy, 1);
      wait_drain("t1_drain", 40);
      chk("t1_grant_after", grant, 0);
      chk("t1_len", log_src.size(), 3);
      exp_beat("t1_b0", 0, 1, 8'h41, 1'b0);
      exp_beat("t1_b1", 1, 1, 8'h42, 1'b0);
      exp_beat("t1_b2", 2, 1, 8'h43, 1'b1);

      // All four sources, two-byte packets; source 0 has a second packet queued.
      do_reset();
      log_clear();
      add_pkt(0, 2, 8'h10);
      add_pkt(0, 2, 8'h50);
      add_pkt(1, 2, 8'h20);
      add_pkt(2, 2, 8'h30);
      add_pkt(3, 2, 8'h40);
      wait_drain("t2_drain", 80);
      chk("t2_len", log_src.size(), 10);
      exp_beat("t2_b0", 0, 0, 8'h10, 1'b0);
      exp_beat("t2_b1", 1, 0, 8'h11, 1'b1);
      exp_beat("t2_b2", 2, 1, 8'h20, 1'b0);
      exp_beat("t2_b4", 4, 2, 8'h30, 1'b0);
      exp_beat("t2_b7", 7, 3, 8'h41, 1'b1);
      exp_beat("t2_b8", 8, 0, 8'h50, 1'b0);
      exp_beat("t2_b9", 9, 0, 8'h51, 1'b1);
      chk("t2_beat_gap", log_cyc[1] - log_cyc[0], 1);
      chk("t2_dead_cycle", log_cyc[2] - log_cyc[1], 2);
      chk("t2_dead_cycle_wrap", log_cyc[8] - log_cyc[7], 2);

      // Backpressure on a four-byte packet from source 2.
      log_clear();
      bp_cnt  = 0;
      bp_mode = 1'b1;
      add_pkt(2, 4, 8'h60);
      tick();
      chk("t3_grant", grant, 4'b0100);
      wait_drain("t3_drain", 60);
      bp_mode = 1'b0;
      m_ready = 1'b1;
      chk("t3_len", log_src.size(), 4);
      exp_beat("t3_b0", 0, 2, 8'h60, 1'b0);
      exp_beat("t3_b1", 1, 2, 8'h61, 1'b0);
      exp_beat("t3_b2", 2, 2, 8'h62, 1'b0);
      exp_beat("t3_b3", 3, 2, 8'h63, 1'b1);

      // Single-beat packets alternating between sources 0 and 3.
      do_reset();
      log_clear();
      add_pkt(0, 1, 8'h70);
      add_pkt(0, 1, 8'h71);
      add_pkt(3, 1, 8'h73);
      add_pkt(3, 1, 8'h74);
      wait_drain("t4_drain", 40);
      chk("t4_len", log_src.size(), 4);
      exp_beat("t4_b0", 0, 0, 8'h70, 1'b1);
      exp_beat("t4_b1", 1, 3, 8'h73, 1'b1);
      exp_beat("t4_b2", 2, 0, 8'h71, 1'b1);
      exp_beat("t4_b3", 3, 3, 8'h74, 1'b1);
      chk("t4_gap0", log_cyc[1] - log_cyc[0], 2);
      chk("t4_gap1", log_cyc[2] - log_cyc[1], 2);

      // Reset after beat 2 of a five-beat packet from source 0.
      log_clear();
      add_pkt(0, 5, 8'h80);
      wait_log("t5_beats", 2, 20);
      rst = 1'b1;
      flush();
      tick();
      chk("t5_grant_rst", grant, 0);
      chk("t5_m_valid_rst", m_valid, 0);
      rst = 1'b0;
      add_pkt(1, 1, 8'h91);
      add_pkt(0, 1, 8'h90);
      tick();
      chk("t5_prio", grant, 4'b0001);
      wait_drain("t5_drain", 20);
      chk("t5_len", log_src.size(), 4);
      exp_beat("t5_b1", 1, 0, 8'h81, 1'b0);
      exp_beat("t5_b2", 2, 0, 8'h90, 1'b1);
      exp_beat("t5_b3", 3, 1, 8'h91, 1'b1);

      // Owner goes quiet mid-packet while source 2 waits.
      do_reset();
      log_clear();
      add_beat(1, 8'hA0, 1'b0);
      tick();
      chk("t6_grant", grant, 4'b0010);
      add_pkt(2, 1, 8'hB0);
      wait_log("t6_beat", 1, 20);
`ifdef ARB_TIMEOUT_EN
      k = 0;
      while (err !== 1'b1 && k < 40) begin
         tick();
         k++;
      end
      chk("t6_err_delay", k, TIMEOUT);
      chk("t6_grant_revoked", grant, 0);
      tick();
      chk("t6_err_pulse", err, 0);
      chk("t6_next_grant", grant, 4'b0100);
      wait_drain("t6_drain", 20);
`else
      for (k = 0; k < 2 * TIMEOUT; k++) tick();
      chk("t6_grant_held", grant, 4'b0010);
      chk("t6_no_err", err, 0);
      do_reset();
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/axis_uart_tx_arb.md
# axis_uart_tx_arb

Packet-granular round-robin arbiter that shares the single AXI-Stream input of the FIFO/UART transmit path among up to NUM_REQ independent byte-stream sources. Each grant holds for one whole packet, delimited by `last`, so bytes from different sources never interleave on the serial line. The arbiter sits between the source masters and the FIFO/UART TX slave, and carries tdata/tvalid/tready/tlast unmodified for the granted source.

## Interface
- `NUM_REQ`, 4: number of requesting sources, 2..8.
- `WIDTH`, 8: data width per source.
- `TIMEOUT`, 1024: stall cycles before a mid-packet grant is revoked. Used only with `ARB_TIMEOUT_EN`.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `s_axis_data`  in  NUM_REQ*WIDTH: source data; source i occupies bits [i*WIDTH +: WIDTH].
- `s_axis_valid`  in  NUM_REQ: per-source valid.
- `s_axis_last`  in  NUM_REQ: per-source end-of-packet.
- `s_axis_ready`  out  NUM_REQ: per-source ready; at most one bit high.
- `m_axis_data`  out  WIDTH: data to the FIFO/UART TX.
- `m_axis_valid`  out  1: valid to the FIFO/UART TX.
- `m_axis_last`  out  1: last to the FIFO/UART TX.
- `m_axis_ready`  in  1: ready from the FIFO/UART TX.
- `grant`  out  NUM_REQ: registered one-hot owner; all zero when idle.
- `busy`  out  1: high while in GRANT.
- `err_timeout`  out  1: one-cycle pulse when a grant is revoked. Tied 0 without `ARB_TIMEOUT_EN`.

## Operation
- **States.**
  - IDLE: no owner.
  - GRANT: one owner, held until its packet completes.
- **IDLE.**
  - Search `s_axis_valid` round-robin, starting at `last_grant+1` and wrapping modulo NUM_REQ.
  - The first requester found is registered into `grant` and the state moves to GRANT.
  - If no source is valid, stay in IDLE.
- **GRANT, owner g.** The path is combinational:
  - `m_axis_data = s_axis_data[g]`, `m_axis_valid = s_axis_valid[g]`, `m_axis_last = s_axis_last[g]`.
  - `s_axis_ready[g] = m_axis_ready`.
  - All other `s_axis_ready` bits are 0.
- **Packet end.**
  - When `m_axis_valid & m_axis_ready & m_axis_last` occurs, set `last_grant <= g`, clear `grant`, and return to IDLE.
  - A single-beat packet (last on the first beat) follows the same rule.
- **Outputs in IDLE.** `m_axis_valid`, `m_axis_last`, `m_axis_data` and all `s_axis_ready` bits are 0.
- **Fairness.**
  - A source that drops valid before it is granted loses its turn; no request is latched.
  - A source that is continuously valid is granted within NUM_REQ-1 packets of other sources.
- **Reset.**
  - State IDLE, `grant` = 0, `busy` = 0, `err_timeout` = 0, `last_grant` = NUM_REQ-1 (source 0 has first priority).
  - Reset asserted mid-packet drops the grant on the next edge with no `last` emitted. The downstream slave is reset by the same `rst`.
- **Invalid `last`.** `s_axis_last` from a non-granted source is ignored.

## Timing
- Arbitration latency: a valid request sampled in IDLE at edge n gives `grant` at n+1. The first beat can transfer in the cycle after edge n+1.
- Turnaround: the `last` beat transfers at edge k, the state is IDLE after k, and the next grant is registered at k+1. This leaves exactly one dead cycle between packets.
- Throughput within a packet is 1 beat/cycle when `m_axis_ready` is held high.
- Backpressure: while `m_axis_ready` is low, the owner sees ready low. The owner must hold data/valid/last stable per AXI-Stream rules; the arbiter does not buffer.
- `grant` and `busy` are registered. `m_axis_*` and `s_axis_ready` are combinational from `grant` and the inputs.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - In GRANT, a counter counts consecutive cycles with owner `s_axis_valid` = 0. It clears on any valid cycle and on grant entry.
  - When the counter reaches TIMEOUT: pulse `err_timeout` for 1 cycle, set `last_grant <= g`, clear `grant`, and go to IDLE.
  - Stalls caused by `m_axis_ready` = 0 are not counted.
  - The counter width is $clog2(TIMEOUT+1), and the counter saturates.
- `ARB_TIMEOUT_EN` undefined: the counter is not built, `err_timeout` = 0, and a grant is held indefinitely until `last`.

## Test plan
- **Reset, then single source.** Source 1 sends 3 bytes 0x41, 0x42, 0x43 with last on 0x43 → `grant` = 4'b0010 one cycle after valid, three beats out in order, `m_axis_last` on 0x43, `grant` = 0 afterwards.
- **All four sources valid, 2-byte packets each.** Grant order is 0,1,2,3,0; exactly one dead cycle between packets; no interleaving of bytes from different sources.
- **Backpressure.** Source 2 holds a 4-byte packet and `m_axis_ready` toggles 1,0,0,1,... → `s_axis_ready[2]` mirrors `m_axis_ready`, no beat is lost or duplicated, and `grant` stays 4'b0100 until last.
- **Single-beat packets.** Sources 0 and 3 each send a 1-byte packet (last on the first beat) back-to-back → each packet takes 1 transfer cycle + 1 dead cycle; `last_grant` alternates 0, 3.
- **Reset mid-packet.** Assert `rst` after beat 2 of 5 from source 0 → next cycle `grant` = 0, `m_axis_valid` = 0, and source 0 has priority again.
- **`ARB_TIMEOUT_EN` with TIMEOUT = 16.** Source 1 drops valid after beat 1 → `err_timeout` pulses exactly 16 cycles later; source 2, waiting, is granted on the next cycle.
